// File: rtl/comp_fp32_pkg.sv
// comp_fp_pkg: shared binary32 field layout, operand classification and
// comparator flag types for the comp_fp32 slice.
// Build option: COMP_FP_DENORM_FLUSH_EN (consumed by fp_classify).
package comp_fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  localparam int FP_KEY_W = FP_EXP_W + FP_MAN_W;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_denorm;
  } fp_class_t;

  typedef struct packed {
    logic ageb;
    logic agb;
    logic aeb;
    logic aleb;
    logic alb;
    logic aneb;
    logic unordered;
  } cmp_flags_t;

  // Expand the one-hot ordered result into the full relational flag set.
  // An unordered pair leaves every relation false except "not equal".
  function automatic cmp_flags_t derive_flags(input logic gt, input logic eq,
                                              input logic lt, input logic unord);
    cmp_flags_t f;
    f.unordered = unord;
    f.agb       = gt & ~unord;
    f.aeb       = eq & ~unord;
    f.alb       = lt & ~unord;
    f.ageb      = f.agb | f.aeb;
    f.aleb      = f.alb | f.aeb;
    f.aneb      = ~f.aeb;
    return f;
  endfunction

endpackage

// File: rtl/comp_fp32_if.sv
// comp_fp32_if: operand and result bundle of the binary32 comparator.
// master drives the operands, slave (the comparator) drives the flags.
interface comp_fp32_if;

  logic [31:0] dataa;
  logic [31:0] datab;
  logic        ageb;
  logic        agb;
  logic        aeb;
  logic        aleb;
  logic        alb;
  logic        aneb;
  logic        unordered;

  modport master (
    output dataa, datab,
    input  ageb, agb, aeb, aleb, alb, aneb, unordered
  );

  modport slave (
    input  dataa, datab,
    output ageb, agb, aeb, aleb, alb, aneb, unordered
  );

endinterface

// File: rtl/comp_fp32_fp_classify.sv
// fp_classify: combinational binary32 operand classifier.
// With COMP_FP_DENORM_FLUSH_EN defined every exponent-0 operand is
// reported as a (signed) zero and no operand is ever reported as denormal.
module fp_classify
  import comp_fp_pkg::*;
(
  input  fp32_t     op_i,
  output fp_class_t cls_o
);

  logic exp_max;
  logic exp_zero;
  logic man_zero;

  // Decode the exponent/mantissa extremes and derive the operand class.
  always_comb begin
    exp_max  = (op_i.exp == FP_EXP_MAX);
    exp_zero = (op_i.exp == '0);
    man_zero = (op_i.man == '0);

    cls_o.is_nan = exp_max & ~man_zero;
    cls_o.is_inf = exp_max & man_zero;
`ifdef COMP_FP_DENORM_FLUSH_EN
    cls_o.is_zero   = exp_zero;
    cls_o.is_denorm = 1'b0;
`else
    cls_o.is_zero   = exp_zero & man_zero;
    cls_o.is_denorm = exp_zero & ~man_zero;
`endif
  end

endmodule

// File: rtl/comp_fp32.sv
// comp_fp32: pipelined IEEE-754 binary32 comparator (A vs B).
// LATENCY (1..3) register stages; stage 1 holds the full comparison result,
// later stages are plain delay registers. Every pipeline register is
// asynchronously cleared by rst_i, so all flags read 0 during reset.
// Build option: COMP_FP_DENORM_FLUSH_EN flushes exponent-0 operands to zero.
module comp_fp32
  import comp_fp_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  comp_fp32_if.slave  cmp_if
);

  fp32_t     op_a;
  fp32_t     op_b;
  fp_class_t cls_a;
  fp_class_t cls_b;

  assign op_a = fp32_t'(cmp_if.dataa);
  assign op_b = fp32_t'(cmp_if.datab);

  fp_classify u_cls_a (
    .op_i  (op_a),
    .cls_o (cls_a)
  );

  fp_classify u_cls_b (
    .op_i  (op_b),
    .cls_o (cls_b)
  );

  logic [FP_KEY_W-1:0] key_a;
  logic [FP_KEY_W-1:0] key_b;
  logic                unord;
  logic                gt;
  logic                eq;
  logic                lt;
  cmp_flags_t          cmp_flags;

  // Order the operands: NaN first, then the zero pair, then sign, then key.
  // A flushed denormal is classified as zero, so its key is forced to 0.
  always_comb begin
    key_a = cls_a.is_zero ? '0 : {op_a.exp, op_a.man};
    key_b = cls_b.is_zero ? '0 : {op_b.exp, op_b.man};
    unord = cls_a.is_nan | cls_b.is_nan;
    gt    = 1'b0;
    eq    = 1'b0;
    lt    = 1'b0;

    if (unord) begin
      gt = 1'b0;
    end else if (cls_a.is_zero && cls_b.is_zero) begin
      eq = 1'b1;
    end else if (op_a.sign != op_b.sign) begin
      gt = ~op_a.sign;
      lt = op_a.sign;
    end else if (!op_a.sign) begin
      gt = (key_a > key_b);
      eq = (key_a == key_b);
      lt = (key_a < key_b);
    end else begin
      gt = (key_a < key_b);
      eq = (key_a == key_b);
      lt = (key_a > key_b);
    end

    cmp_flags = derive_flags(gt, eq, lt, unord);
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_pipe
    cmp_flags_t flags_d;
    cmp_flags_t flags_q;

    if (s == 0) begin : g_first
      // Stage 1 captures the freshly computed comparison result.
      always_comb flags_d = cmp_flags;
    end else begin : g_delay
      // Later stages only delay the previous stage's result.
      always_comb flags_d = g_pipe[s-1].flags_q;
    end

    // Stage register, cleared asynchronously so in-flight results are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) flags_q <= '0;
      else       flags_q <= flags_d;
    end
  end

  cmp_flags_t flags_out;
  assign flags_out = g_pipe[LATENCY-1].flags_q;

  assign cmp_if.ageb      = flags_out.ageb;
  assign cmp_if.agb       = flags_out.agb;
  assign cmp_if.aeb       = flags_out.aeb;
  assign cmp_if.aleb      = flags_out.aleb;
  assign cmp_if.alb       = flags_out.alb;
  assign cmp_if.aneb      = flags_out.aneb;
  assign cmp_if.unordered = flags_out.unordered;

endmodule

// File: tb/tb_comp_fp32.sv
// tb_comp_fp32: drives a LATENCY=1 and a LATENCY=3 comparator with the same
// operand stream; directed table, reset sequences and random pairs checked
// against a real-number reference model.
module tb_comp_fp32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  comp_fp32_if if1 ();
  comp_fp32_if if3 ();

  comp_fp32 #(.LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst), .cmp_if(if1));
  comp_fp32 #(.LATENCY(3)) dut3 (.clk_i(clk), .rst_i(rst), .cmp_if(if3));

  // Flag vectors ordered {ageb, agb, aeb, aleb, alb, aneb, unordered}.
  logic [6:0] got1;
  logic [6:0] got3;
  assign got1 = {if1.ageb, if1.agb, if1.aeb, if1.aleb, if1.alb, if1.aneb, if1.unordered};
  assign got3 = {if3.ageb, if3.agb, if3.aeb, if3.aleb, if3.alb, if3.aneb, if3.unordered};

  localparam logic [6:0] F_GT = 7'b1100010;
  localparam logic [6:0] F_EQ = 7'b1011000;
  localparam logic [6:0] F_LT = 7'b0001110;
  localparam logic [6:0] F_UN = 7'b0000011;

  // Numeric value of a non-NaN binary32 pattern; infinity maps to a real far
  // beyond the largest finite float.
  function automatic real fp_val(input logic [31:0] x);
    int  e;
    real mag;
    e = int'(x[30:23]);
`ifdef COMP_FP_DENORM_FLUSH_EN
    if (e == 0) return 0.0;
`endif
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else             mag = real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [6:0] model(input logic [31:0] a, input logic [31:0] b);
    real va;
    real vb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return F_UN;
    va = fp_val(a);
    vb = fp_val(b);
    if (va > vb) return F_GT;
    if (va < vb) return F_LT;
    return F_EQ;
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got flags %b, expected %b", name, got, exp);
    end
  endtask

  // Pending LATENCY=3 expectations, primed with two zero results.
  logic [6:0] hist[$];

  // Present one pair at the falling edge, clock it in, check both DUTs.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] exp1, input string name);
    if1.dataa = a; if1.datab = b;
    if3.dataa = a; if3.datab = b;
    hist.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    check({name, "_l1"}, got1, exp1);
    check({name, "_l3"}, got3, hist.pop_front());
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: begin
        case ($urandom_range(0, 5))
          0: r = 32'h7F800000;
          1: r = 32'hFF800000;
          2: r = 32'h7FC00000;
          3: r = 32'h80000000;
          4: r = 32'h00000000;
          default: r = 32'hFF800001;
        endcase
      end
      1: r = {r[31], 8'h00, r[22:0]};
      2: r = {r[31], 8'h00, 20'h0, r[2:0]};
      3: r = {r[31], 8'hFE, r[22:0]};
      default: r = {r[31], 8'(126 + $urandom_range(0, 3)), r[22:0]};
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    tbl.push_back('{32'h3F800000, 32'h40000000, F_LT, "one_vs_two"});
    tbl.push_back('{32'hBF800000, 32'hC0000000, F_GT, "neg1_vs_neg2"});
    tbl.push_back('{32'h80000000, 32'h00000000, F_EQ, "negzero_vs_zero"});
    tbl.push_back('{32'h7F800000, 32'h7F7FFFFF, F_GT, "inf_vs_max"});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, F_UN, "nan_vs_one"});
    tbl.push_back('{32'h3F800000, 32'h7FC00000, F_UN, "one_vs_nan"});
    tbl.push_back('{32'hFF800000, 32'h7F800000, F_LT, "neginf_vs_inf"});
    tbl.push_back('{32'h7F800000, 32'h7F800000, F_EQ, "inf_vs_inf"});
    tbl.push_back('{32'h3F800000, 32'h3F800000, F_EQ, "one_vs_one"});
    tbl.push_back('{32'hC0000000, 32'hBF800000, F_LT, "neg2_vs_neg1"});
    tbl.push_back('{32'hFF800001, 32'hFF800001, F_UN, "nan_vs_nan"});
    tbl.push_back('{32'h00000000, 32'hBF800000, F_GT, "zero_vs_neg1"});
`ifdef COMP_FP_DENORM_FLUSH_EN
    tbl.push_back('{32'h00000001, 32'h00000000, F_EQ, "denorm_vs_zero"});
    tbl.push_back('{32'h80000000, 32'h00000001, F_EQ, "negzero_vs_denorm"});
    tbl.push_back('{32'h00000002, 32'h00000001, F_EQ, "denorm_vs_denorm"});
`else
    tbl.push_back('{32'h00000001, 32'h00000000, F_GT, "denorm_vs_zero"});
    tbl.push_back('{32'h80000000, 32'h00000001, F_LT, "negzero_vs_denorm"});
    tbl.push_back('{32'h00000002, 32'h00000001, F_GT, "denorm_vs_denorm"});
`endif

    // Reset held with A=2.0, B=1.0: everything must read 0.
    rst = 1'b1;
    if1.dataa = 32'h40000000; if1.datab = 32'h3F800000;
    if3.dataa = 32'h40000000; if3.datab = 32'h3F800000;
    repeat (3) @(negedge clk);
    check("reset_hold_l1", got1, 7'b0);
    check("reset_hold_l3", got3, 7'b0);
    rst = 1'b0;
    hist = '{7'b0, 7'b0};
    step(32'h40000000, 32'h3F800000, F_GT, "rst_release");

    // Directed table, back to back.
    foreach (tbl[i]) step(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

    // Mid-stream reset clears results immediately, then refills in order.
    step(32'h40000000, 32'h3F800000, F_GT, "pre_rst_a");
    step(32'h3F800000, 32'h40000000, F_LT, "pre_rst_b");
    rst = 1'b1;
    #1;
    check("midrst_async_l1", got1, 7'b0);
    check("midrst_async_l3", got3, 7'b0);
    @(negedge clk);
    check("midrst_held_l1", got1, 7'b0);
    check("midrst_held_l3", got3, 7'b0);
    rst = 1'b0;
    hist = '{7'b0, 7'b0};
    step(32'hBF800000, 32'hC0000000, F_GT, "post_rst_a");
    step(32'h7FC00000, 32'h3F800000, F_UN, "post_rst_b");
    step(32'h80000000, 32'h00000000, F_EQ, "post_rst_c");
    step(32'h3F800000, 32'h40000000, F_LT, "post_rst_d");

    // Random pairs, a new pair every cycle.
    for (int n = 0; n < 400; n++) begin
      a = rand_op();
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = a ^ 32'h80000000;
        2: b = a + 32'd1;
        default: b = rand_op();
      endcase
      step(a, b, model(a, b), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_fp32.md
# comp_fp32

Pipelined IEEE-754 single-precision comparator. Samples two 32-bit floating-point operands every clock and produces registered relational flags, most importantly `ageb` (A ≥ B). It sits in the cascade classifier datapath, where it compares a stage threshold (A) against an accumulated stage sum (B) to decide whether a detection window passes a stage.

## Interface
- `LATENCY`, default 1: pipeline depth in clocks, legal range 1..3.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `dataa`  in  32: operand A, IEEE-754 binary32.
- `datab`  in  32: operand B, IEEE-754 binary32.
- `ageb`  out  1: A ≥ B.
- `agb`  out  1: A > B.
- `aeb`  out  1: A == B.
- `aleb`  out  1: A ≤ B.
- `alb`  out  1: A < B.
- `aneb`  out  1: A != B, including the unordered case.
- `unordered`  out  1: at least one operand is NaN.

## Operation
- Field split: sign `[31]`, exponent `[30:23]`, mantissa `[22:0]`.
- NaN: exponent = 0xFF and mantissa != 0.
- Infinity: exponent = 0xFF and mantissa == 0. Infinities are ordinary ordered values.
- Zero: exponent = 0 and mantissa == 0. +0 and −0 compare equal.
- Magnitude key: the unsigned 31-bit `{exp, man}`.
- Ordering rules:
  - Same sign, positive: compare keys directly.
  - Same sign, negative: compare keys inverted.
  - Opposite signs: the positive operand is greater, unless both are zero, in which case the operands are equal.
- Denormals are ordered exactly by key unless `COMP_FP_DENORM_FLUSH_EN` is defined (see Configuration).
- Unordered (either operand NaN):
  - `unordered` = 1 and `aneb` = 1.
  - `ageb`, `agb`, `aeb`, `aleb` and `alb` are all 0.
- Ordered case: exactly one of `agb`/`aeb`/`alb` is 1. The derived flags are `ageb` = agb|aeb, `aleb` = alb|aeb, `aneb` = !aeb.
- No handshake. The comparator accepts a new operand pair every cycle and is fully pipelined.

## Timing
- The operands sampled at rising edge N appear on all outputs after edge N+LATENCY-1, i.e. registered, one clock for LATENCY = 1.
- When LATENCY > 1:
  - Stage 1 registers the classification and the key comparison.
  - The remaining stages are delay registers.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.
- Reset values: every pipeline register is cleared to 0, so all seven outputs are 0, including `aneb`.
- Reset asserted mid-stream:
  - All in-flight results are discarded immediately (asynchronous clear).
  - Outputs stay 0 until LATENCY edges after `rst_i` deasserts have captured fresh operands.
- Operands may change every cycle. Each output word corresponds strictly to a single sampled pair, never a mix of two pairs.

## Configuration
- Macro `COMP_FP_DENORM_FLUSH_EN`.
- When defined, any operand with exponent = 0 is treated as a signed zero before comparison. Two denormals, or a denormal and a zero, therefore compare equal.
- When undefined, denormals compare exactly, so 0x00000001 > 0x00000000.

## Structure
- Package `comp_fp_pkg` holds:
  - Constants `FP_EXP_W` = 8, `FP_MAN_W` = 23, `FP_EXP_MAX` = 8'hFF.
  - Packed struct `fp32_t {sign, exp, man}`.
  - Struct `fp_class_t {is_nan, is_inf, is_zero, is_denorm}`.
- One sub-module, `fp_classify`: purely combinational. It takes an `fp32_t` and returns an `fp_class_t`, honouring the flush macro. It is instantiated once per operand.
- The top level contains the key comparison, the flag derivation and a generate-built pipeline of depth LATENCY.

## Test plan
- Reset: hold `rst_i` = 1 with A = 0x40000000 and B = 0x3F800000. All outputs must read 0. One edge after release, `ageb` = 1 and `agb` = 1.
- Ordered values, LATENCY = 1:
  - A = 0x3F800000 (1.0), B = 0x40000000 (2.0) → `alb` = 1, `aleb` = 1, `ageb` = 0.
  - Then A = 0xBF800000 (−1.0), B = 0xC0000000 (−2.0) → `agb` = 1, `ageb` = 1.
- Signed zeros and infinities:
  - A = 0x80000000, B = 0x00000000 → `aeb` = 1, `ageb` = 1, `aneb` = 0.
  - A = 0x7F800000 (+inf), B = 0x7F7FFFFF → `agb` = 1.
- NaN: A = 0x7FC00000, B = 0x3F800000 → `unordered` = 1, `aneb` = 1, all other flags 0. The same response is required with the operands swapped.
- Back-to-back throughput: change operands every cycle with LATENCY = 3. Each result must appear exactly 3 edges after its pair was sampled, in order. Assert `rst_i` mid-stream → all outputs 0 immediately.
- Denormal handling: A = 0x00000001, B = 0x00000000.
  - Without the macro: `agb` = 1.
  - With `COMP_FP_DENORM_FLUSH_EN`: `aeb` = 1.
